// File: rtl/alarm_responder.sv
// Alarm response sequencer: arm/exit/entry/alarm/silence with zone latching, siren and strobe.
// Optional macro ALARM_CHIRP_EN: siren chirps on each tick during EXIT and ENTRY.
module alarm_responder #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned EXIT_DLY  = 30,
  parameter int unsigned ENTRY_DLY = 15,
  parameter int unsigned SIREN_MAX = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       disarm,
  input  logic       trip,
  input  logic [3:0] zone,
  output logic       siren,
  output logic       strobe,
  output logic [2:0] state,
  output logic [3:0] zone_latched
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_SILENCED = 3'd5
  } state_e;

  localparam int unsigned MAXD01 = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int unsigned MAXD   = (MAXD01 > SIREN_MAX) ? MAXD01 : SIREN_MAX;
  localparam int unsigned TCW    = $clog2(MAXD + 1);
  localparam int unsigned PW     = $clog2(TICK_DIV);

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [3:0]     zl_q, zl_d;
  logic           siren_q, siren_d;
  logic           strobe_q, strobe_d;
  logic           arm_q, disarm_q;
  logic           arm_edge, dis_edge, tick, moved;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_DISARMED;
      presc_q  <= '0;
      tcnt_q   <= '0;
      zl_q     <= '0;
      siren_q  <= 1'b0;
      strobe_q <= 1'b0;
      // Held high so a level already asserted at reset release is not an edge.
      arm_q    <= 1'b1;
      disarm_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tcnt_q   <= tcnt_d;
      zl_q     <= zl_d;
      siren_q  <= siren_d;
      strobe_q <= strobe_d;
      arm_q    <= arm;
      disarm_q <= disarm;
    end
  end

  always_comb begin
    arm_edge = arm & ~arm_q;
    dis_edge = disarm & ~disarm_q;
    tick     = (presc_q == PW'(TICK_DIV - 1));
    state_d  = state_q;
    zl_d     = zl_q;

    case (state_q)
      S_DISARMED: if (arm_edge && !dis_edge) state_d = S_EXIT;
      S_EXIT:     if (tick && tcnt_q == TCW'(EXIT_DLY - 1)) state_d = S_ARMED;
      S_ARMED: begin
        if (trip) begin
          state_d = S_ENTRY;
          zl_d    = zone;
        end
      end
      S_ENTRY: begin
        if (trip) zl_d = zl_q | zone;
        if (tick && tcnt_q == TCW'(ENTRY_DLY - 1)) state_d = S_ALARM;
      end
      S_ALARM: begin
        if (trip) zl_d = zl_q | zone;
        if (tick && tcnt_q == TCW'(SIREN_MAX - 1)) state_d = S_SILENCED;
      end
      S_SILENCED: if (trip) zl_d = zl_q | zone;
      default:    state_d = S_DISARMED;
    endcase

    if (dis_edge && state_q != S_DISARMED) begin
      state_d = S_DISARMED;
      zl_d    = '0;
    end

    // Counters restart on every transition so each delay is measured exactly.
    moved   = (state_d != state_q);
    presc_d = (moved || tick) ? '0 : presc_q + PW'(1);
    tcnt_d  = moved ? '0 : (tick ? tcnt_q + TCW'(1) : tcnt_q);

    // Strobe phase carries across ALARM->SILENCED; forced low elsewhere.
    strobe_d = 1'b0;
    if (state_d == S_ALARM || state_d == S_SILENCED)
      strobe_d = strobe_q ^ (tick && (state_q == S_ALARM || state_q == S_SILENCED));

`ifdef ALARM_CHIRP_EN
    siren_d = 1'b0;
    if (state_d == S_ALARM)
      siren_d = 1'b1;
    else if (!moved && (state_q == S_EXIT || state_q == S_ENTRY))
      siren_d = siren_q ^ tick;
`else
    siren_d = (state_d == S_ALARM);
`endif
  end

  assign state        = state_q;
  assign siren        = siren_q;
  assign strobe       = strobe_q;
  assign zone_latched = zl_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Directed self-checking bench for alarm_responder (TICK_DIV=4, EXIT=3, ENTRY=2, SIREN=5).
module tb_alarm_responder;

  logic       clk = 1'b0;
  logic       rst_n, arm, disarm, trip;
  logic [3:0] zone;
  logic       siren, strobe;
  logic [2:0] state;
  logic [3:0] zone_latched;

  int n_checks = 0;
  int n_errors = 0;

  alarm_responder #(
    .TICK_DIV (4),
    .EXIT_DLY (3),
    .ENTRY_DLY(2),
    .SIREN_MAX(5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .disarm      (disarm),
    .trip        (trip),
    .zone        (zone),
    .siren       (siren),
    .strobe      (strobe),
    .state       (state),
    .zone_latched(zone_latched)
  );

  always #5 clk = ~clk;

`ifdef ALARM_CHIRP_EN
  localparam logic CHIRP = 1'b1;
`else
  localparam logic CHIRP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; trip = 1'b0; zone = 4'b0;
    step(2);
    check("rst_state", state, 0);
    check("rst_siren", siren, 0);
    check("rst_strobe", strobe, 0);
    check("rst_zl", zone_latched, 0);
    rst_n = 1'b1;
    step(1);

    // Arm: edge 0 drive, EXIT from edge 1, ARMED from edge 13.
    arm = 1'b1;
    step(1);
    check("exit_enter", state, 1);
    check("exit_siren0", siren, 0);
    arm = 1'b0;
    step(3);
    check("exit_e4", state, 1);
    step(1);
    check("exit_chirp1", siren, CHIRP);
    step(4);
    check("exit_chirp2", siren, 0);
    trip = 1'b1; zone = 4'b1000;
    step(3);
    check("exit_e12", state, 1);
    check("exit_trip_ign", zone_latched, 0);
    trip = 1'b0; zone = 4'b0;
    step(1);
    check("armed_enter", state, 2);
    check("armed_siren", siren, 0);

    // Arm edge while ARMED is ignored.
    arm = 1'b1;
    step(1);
    check("armed_arm_ign", state, 2);
    arm = 1'b0;
    step(1);

    // Full alarm sequence.
    trip = 1'b1; zone = 4'b0100;
    step(1);
    check("entry_enter", state, 3);
    check("entry_zl", zone_latched, 4'b0100);
    trip = 1'b0; zone = 4'b0;
    step(4);
    check("entry_chirp", siren, CHIRP);
    step(3);
    check("entry_e7", state, 3);
    step(1);
    check("alarm_enter", state, 4);
    check("alarm_siren", siren, 1);
    check("alarm_strobe0", strobe, 0);
    step(4);
    check("strobe_t1", strobe, 1);
    step(4);
    check("strobe_t2", strobe, 0);
    trip = 1'b1; zone = 4'b0001;
    step(1);
    check("zone_accum", zone_latched, 4'b0101);
    trip = 1'b0; zone = 4'b0;
    step(3);
    check("strobe_t3", strobe, 1);
    step(7);
    check("alarm_e19", state, 4);
    check("alarm_e19_strobe", strobe, 0);
    step(1);
    check("silenced", state, 5);
    check("silenced_siren", siren, 0);
    check("silenced_strobe", strobe, 1);
    step(4);
    check("silenced_strobe2", strobe, 0);
    check("silenced_stay", state, 5);
    disarm = 1'b1;
    step(1);
    check("disarm_state", state, 0);
    check("disarm_zl", zone_latched, 0);
    check("disarm_strobe", strobe, 0);
    disarm = 1'b0;
    step(1);

    // Disarm beats trip in ENTRY.
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(12);
    check("p_armed", state, 2);
    trip = 1'b1; zone = 4'b0010;
    step(1);
    check("p_entry", state, 3);
    trip = 1'b0; zone = 4'b0;
    step(2);
    disarm = 1'b1; trip = 1'b1; zone = 4'b1111;
    step(1);
    check("prio_state", state, 0);
    check("prio_zl", zone_latched, 0);
    disarm = 1'b0; trip = 1'b0; zone = 4'b0;
    step(1);

    // Reset mid-alarm, with arm held high across release.
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(12);
    trip = 1'b1; zone = 4'b1001;
    step(1);
    trip = 1'b0; zone = 4'b0;
    step(8);
    check("r_alarm", state, 4);
    step(4);
    check("r_strobe", strobe, 1);
    rst_n = 1'b0; arm = 1'b1;
    step(1);
    check("r_state", state, 0);
    check("r_siren", siren, 0);
    check("r_strobe0", strobe, 0);
    check("r_zl", zone_latched, 0);
    rst_n = 1'b1;
    step(4);
    check("r_arm_held", state, 0);
    arm = 1'b0;
    step(1);
    arm = 1'b1;
    step(1);
    check("r_rearm", state, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
